// File: rtl/seg7_scan_driver_if.sv
// Value-input handshake for the 7-segment scan driver.
// The producer drives bin_in/bin_valid, and the driver answers with bin_ready.
interface seg7_scan_driver_if;
  logic [13:0] bin_in;
  logic        bin_valid;
  logic        bin_ready;

  modport master (
    output bin_in,
    output bin_valid,
    input  bin_ready
  );

  modport slave (
    input  bin_in,
    input  bin_valid,
    output bin_ready
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver.
// A binary value is converted to BCD by a 14-step double-dabble FSM and latched
// into the display register. A free-running prescaler steps a scan index that
// drives the digit enables and the per-digit BCD code. An optional
// leading-zero blanking mode emits 4'hF, which the downstream decoder shows as
// all segments off.
module seg7_scan_driver #(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  seg7_scan_driver_if.slave     bin_bus,
  input  logic                  blank_en,
  output logic                  conv_done,
  output logic [3:0]            bcd_out,
  output logic [3:0]            dig_sel_n
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [19:0] DIV_LAST = 20'(CLK_DIV - 1);

  // Clamp the input to the largest value that four decimal digits can show.
  function automatic logic [13:0] saturate(input logic [13:0] v);
    if (v > 14'd9999) begin
      saturate = 14'd9999;
    end else begin
      saturate = v;
    end
  endfunction

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  function automatic logic [15:0] dd_adjust(input logic [15:0] v);
    logic [3:0] nib;
    dd_adjust = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      nib = v[4*i +: 4];
      if (nib >= 4'd5) begin
        dd_adjust[4*i +: 4] = nib + 4'd3;
      end else begin
        dd_adjust[4*i +: 4] = nib;
      end
    end
  endfunction

  // Select a display digit. Blank it when blanking is on and this digit and
  // all higher digits are zero. The ones digit is never blanked.
  function automatic logic [3:0] scan_digit(input logic [15:0] disp,
                                            input logic [1:0]  idx,
                                            input logic        blank);
    logic zero_above;
    case (idx)
      2'd3:    zero_above = (disp[15:12] == 4'h0);
      2'd2:    zero_above = (disp[15:8]  == 8'h00);
      2'd1:    zero_above = (disp[15:4]  == 12'h000);
      2'd0:    zero_above = 1'b0;
      default: zero_above = 1'b0;
    endcase
    if (blank && zero_above) begin
      scan_digit = 4'hF;
    end else begin
      scan_digit = disp[{idx, 2'b00} +: 4];
    end
  endfunction

  state_t      state_r;
  state_t      state_next_s;
  logic [13:0] shift_r;
  logic [13:0] shift_next_s;
  logic [15:0] acc_r;
  logic [15:0] acc_next_s;
  logic [15:0] acc_adj_s;
  logic [3:0]  step_r;
  logic [3:0]  step_next_s;
  logic [15:0] disp_r;
  logic        disp_load_s;
  logic        ready_r;
  logic        conv_done_r;

  logic [19:0] presc_r;
  logic [1:0]  idx_r;
  logic [1:0]  idx_next_s;
  logic        tick_s;
  logic [3:0]  dig_sel_n_r;
  logic [3:0]  bcd_out_r;

  assign bin_bus.bin_ready = ready_r;
  assign conv_done         = conv_done_r;
  assign bcd_out           = bcd_out_r;
  assign dig_sel_n         = dig_sel_n_r;

  // Conversion FSM next-state and datapath: capture, 14 shift steps, then load.
  always_comb begin
    state_next_s = state_r;
    shift_next_s = shift_r;
    acc_next_s   = acc_r;
    step_next_s  = step_r;
    disp_load_s  = 1'b0;
    acc_adj_s    = dd_adjust(acc_r);
    case (state_r)
      IDLE: begin
        if (bin_bus.bin_valid && ready_r) begin
          shift_next_s = saturate(bin_bus.bin_in);
          acc_next_s   = 16'h0000;
          step_next_s  = 4'd0;
          state_next_s = CONV;
        end else begin
          state_next_s = IDLE;
        end
      end
      CONV: begin
        {acc_next_s, shift_next_s} = {acc_adj_s[14:0], shift_r, 1'b0};
        step_next_s = step_r + 4'd1;
        if (step_r == 4'd13) begin
          state_next_s = DONE;
        end else begin
          state_next_s = CONV;
        end
      end
      DONE: begin
        disp_load_s  = 1'b1;
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Conversion state, datapath, display register, ready and done registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      shift_r     <= 14'd0;
      acc_r       <= 16'h0000;
      step_r      <= 4'd0;
      disp_r      <= 16'h0000;
      ready_r     <= 1'b1;
      conv_done_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      shift_r     <= shift_next_s;
      acc_r       <= acc_next_s;
      step_r      <= step_next_s;
      ready_r     <= (state_next_s == IDLE);
      conv_done_r <= disp_load_s;
      if (disp_load_s) begin
        disp_r <= acc_r;
      end
    end
  end

  assign tick_s     = (presc_r == DIV_LAST);
  assign idx_next_s = idx_r + 2'd1;

  // Free-running prescaler and scan index; outputs refresh together on each tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r     <= 20'd0;
      idx_r       <= 2'd0;
      dig_sel_n_r <= 4'b1110;
      bcd_out_r   <= 4'h0;
    end else if (tick_s) begin
      presc_r     <= 20'd0;
      idx_r       <= idx_next_s;
      dig_sel_n_r <= ~(4'b0001 << idx_next_s);
      bcd_out_r   <= scan_digit(disp_r, idx_next_s, blank_en);
    end else begin
      presc_r     <= presc_r + 20'd1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver with CLK_DIV=4.
module tb_seg7_scan_driver;
  logic       clk = 1'b0;
  logic       rst;
  logic       blank_en;
  logic       conv_done;
  logic [3:0] bcd_out;
  logic [3:0] dig_sel_n;

  int n_tests = 0;
  int n_fail  = 0;
  int n_edges = 0;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(.CLK_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bin_bus   (bus),
    .blank_en  (blank_en),
    .conv_done (conv_done),
    .bcd_out   (bcd_out),
    .dig_sel_n (dig_sel_n)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the scan index is (n_edges/4)%4.
  always @(posedge clk) begin
    if (rst) n_edges <= 0;
    else     n_edges <= n_edges + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference digit: decimal digit i of min(v,9999), blanked if leading zero.
  function automatic logic [3:0] ref_digit(input int v, input int i, input logic blank);
    int s;
    int p;
    s = (v > 9999) ? 9999 : v;
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    if (blank && i > 0 && s < p) return 4'hF;
    return 4'((s / p) % 10);
  endfunction

  function automatic logic [3:0] ref_sel(input int i);
    logic [3:0] one;
    one = 4'b0001 << i;
    return ~one;
  endfunction

  // Send one value and check the handshake and done-pulse timing around it.
  task automatic xfer(input int v);
    chk("ready_pre", 16'(bus.bin_ready), 16'd1);
    bus.bin_in    = 14'(v);
    bus.bin_valid = 1'b1;
    step();                       // E0
    bus.bin_valid = 1'b0;
    for (int k = 0; k < 15; k++) begin
      chk("ready_busy", 16'(bus.bin_ready), 16'd0);
      chk("done_early", 16'(conv_done), 16'd0);
      step();
    end                           // now after E15
    chk("done_pulse", 16'(conv_done), 16'd1);
    chk("ready_back", 16'(bus.bin_ready), 16'd1);
    step();                       // E16
    chk("done_one_cycle", 16'(conv_done), 16'd0);
  endtask

  // Wait for the scan to re-enter index 0, then check all four slots.
  task automatic scan_check(input int v, input logic blank);
    int guard;
    guard = 0;
    while (dig_sel_n == 4'b1110 && guard < 20) begin step(); guard++; end
    while (dig_sel_n != 4'b1110 && guard < 40) begin step(); guard++; end
    chk("scan_sync", 16'(dig_sel_n), 16'(4'b1110));
    for (int i = 0; i < 4; i++) begin
      chk("scan_sel", 16'(dig_sel_n), 16'(ref_sel(i)));
      chk("scan_bcd", 16'(bcd_out), 16'(ref_digit(v, i, blank)));
      repeat (4) step();
    end
  endtask

  initial begin
    rst           = 1'b1;
    blank_en      = 1'b0;
    bus.bin_in    = 14'd0;
    bus.bin_valid = 1'b0;
    repeat (3) step();
    chk("rst_sel", 16'(dig_sel_n), 16'(4'b1110));
    chk("rst_bcd", 16'(bcd_out), 16'h0);
    chk("rst_ready", 16'(bus.bin_ready), 16'd1);
    chk("rst_done", 16'(conv_done), 16'd0);
    rst = 1'b0;

    // Idle scan: index steps every 4 edges.
    for (int k = 0; k < 16; k++) begin
      step();
      chk("idle_scan", 16'(dig_sel_n), 16'(ref_sel((n_edges / 4) % 4)));
    end

    xfer(1234);   scan_check(1234, 1'b0);
    xfer(12000);  scan_check(12000, 1'b0);
    xfer(0);      scan_check(0, 1'b0);
    blank_en = 1'b1;
    xfer(7);      scan_check(7, 1'b1);
    xfer(0);      scan_check(0, 1'b1);
    xfer(1005);   scan_check(1005, 1'b1);
    blank_en = 1'b0;

    // Busy: valid held with 5555 during the 1234 conversion.
    bus.bin_in    = 14'd1234;
    bus.bin_valid = 1'b1;
    step();                       // E0
    bus.bin_in = 14'd5555;
    for (int k = 0; k < 15; k++) begin
      chk("busy_ready", 16'(bus.bin_ready), 16'd0);
      step();
    end                           // after E15
    chk("busy_done1", 16'(conv_done), 16'd1);
    chk("busy_ready15", 16'(bus.bin_ready), 16'd1);
    step();                       // E16: 5555 accepted
    bus.bin_valid = 1'b0;
    chk("busy_accept", 16'(bus.bin_ready), 16'd0);
    chk("busy_done_lo", 16'(conv_done), 16'd0);
    repeat (4) step();            // after E20
    chk("busy_sel", 16'(dig_sel_n), 16'(ref_sel((n_edges / 4) % 4)));
    chk("busy_disp", 16'(bcd_out), 16'(ref_digit(1234, (n_edges / 4) % 4, 1'b0)));
    repeat (10) step();           // after E30
    chk("busy_done_e30", 16'(conv_done), 16'd0);
    step();                       // after E31
    chk("busy_done_e31", 16'(conv_done), 16'd1);
    scan_check(5555, 1'b0);

    // Reset abort five cycles into a conversion.
    bus.bin_in    = 14'd4321;
    bus.bin_valid = 1'b1;
    step();
    bus.bin_valid = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    step();
    chk("abort_done", 16'(conv_done), 16'd0);
    rst = 1'b0;
    chk("abort_ready", 16'(bus.bin_ready), 16'd1);
    begin
      logic saw;
      saw = 1'b0;
      repeat (20) begin
        step();
        if (conv_done) saw = 1'b1;
      end
      chk("abort_no_pulse", 16'(saw), 16'd0);
    end
    scan_check(0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
